// File: rtl/sc_mac_seq.sv
// -----------------------------------------------------------------------------
// sc_mac_seq
//
// Sequencer for one stochastic-computing MAC lane. Each accepted operand pair
// is driven onto the MAC's BN_X/BN_Y inputs. The MAC's SNGs/LFSR are then
// cleared for one cycle and the MAC pipeline is flushed. After that, the ones
// in the MAC output stream Q are counted over a full window of STREAM_LEN
// cycles. NTERMS such counts are summed into a binary dot-product result,
// which is offered on a valid/ready output port.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   operand pair valid
//   in_ready   out  sequencer can accept a pair (IDLE only)
//   in_x/in_y  in   BN operands, BW bits each
//   abort      in   synchronous abort of the current dot product
//   mac_x/y    out  operands held stable towards the MAC BN_X/BN_Y
//   mac_clr    out  one-cycle clear pulse for the MAC SNGs/LFSR
//   mac_q      in   MAC stochastic output bit
//   out_valid  out  dot-product result valid
//   out_ready  in   consumer accepts the result
//   out_sum    out  accumulated ones count (ACC_W bits)
//   busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module sc_mac_seq #(
  parameter int BW         = 7,
  parameter int STREAM_LEN = 128,
  parameter int PIPE_LAT   = 2,
  parameter int NTERMS     = 4,
  parameter int ACC_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_x,
  input  logic [BW-1:0]    in_y,
  input  logic             abort,
  output logic [BW-1:0]    mac_x,
  output logic [BW-1:0]    mac_y,
  output logic             mac_clr,
  input  logic             mac_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  // Ones counter must hold a full window of ones.
  localparam int ONES_W = $clog2(STREAM_LEN + 1);
  // One shared cycle counter serves both the FLUSH and the STREAM phase.
  localparam int CNT_MAX = (STREAM_LEN > PIPE_LAT) ? STREAM_LEN : PIPE_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TERM_W  = $clog2(NTERMS + 1);

  localparam logic [CNT_W-1:0]  FLUSH_LAST  = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0]  STREAM_LAST = CNT_W'(STREAM_LEN - 1);
  localparam logic [TERM_W-1:0] TERM_LAST   = TERM_W'(NTERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [BW-1:0]       r_mac_x;
  logic [BW-1:0]       r_mac_y;
  logic                r_mac_clr;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [ACC_W-1:0]    r_out_sum;
  logic                r_busy;
  logic [ACC_W-1:0]    r_acc;
  logic [ONES_W-1:0]   r_ones;
  logic [CNT_W-1:0]    r_cnt;
  logic [TERM_W-1:0]   r_term;

  logic [ACC_W-1:0]    w_acc_next;

  // The bit arriving on the last STREAM cycle is not yet in r_ones. It is
  // added here directly, so the window closes on the same edge as the count.
  always_comb begin
    w_acc_next = r_acc + ACC_W'(r_ones) + ACC_W'(mac_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mac_x     <= '0;
      r_mac_y     <= '0;
      r_mac_clr   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_ones      <= '0;
      r_cnt       <= '0;
      r_term      <= '0;
    end else if (abort) begin
      // Abort wins over a same-cycle handshake and discards any partial sum.
      // In IDLE, only the accumulator and the term index change; the other
      // fields already hold these values.
      r_state     <= S_IDLE;
      r_mac_clr   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_ones      <= '0;
      r_cnt       <= '0;
      r_term      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Operands stay on the MAC inputs until the next accepted pair.
            r_mac_x    <= in_x;
            r_mac_y    <= in_y;
            r_mac_clr  <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_mac_clr <= 1'b0;
          r_ones    <= '0;
          r_cnt     <= '0;
          r_state   <= (PIPE_LAT == 0) ? S_STREAM : S_FLUSH;
        end

        S_FLUSH: begin
          // Q carries no valid data while the MAC pipeline refills.
          if (r_cnt == FLUSH_LAST) begin
            r_cnt   <= '0;
            r_state <= S_STREAM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STREAM: begin
          r_ones <= r_ones + ONES_W'(mac_q);
          if (r_cnt == STREAM_LAST) begin
            r_cnt  <= '0;
            r_ones <= '0;
            r_acc  <= w_acc_next;
            r_term <= r_term + TERM_W'(1);
            if (r_term == TERM_LAST) begin
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_next;
              r_state     <= S_DONE;
            end else begin
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          // Result is held until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_term      <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_mac_clr   <= 1'b0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign mac_x     = r_mac_x;
  assign mac_y     = r_mac_y;
  assign mac_clr   = r_mac_clr;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sc_mac_seq.sv
module tb_sc_mac_seq;

  localparam int BW    = 7;
  localparam int ACC_W = 10;
  localparam int TERM_CYC = 131;  // 1 + PIPE_LAT + STREAM_LEN

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BW-1:0]    in_x = '0;
  logic [BW-1:0]    in_y = '0;
  logic             abort = 1'b0;
  logic [BW-1:0]    mac_x;
  logic [BW-1:0]    mac_y;
  logic             mac_clr;
  logic             mac_q = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic             busy;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int         mode;     // 0: Q=0, 1: Q=1, 2: toggle in STREAM, 3: Q=1 only in LOAD/FLUSH
    logic [6:0] x;
    logic [6:0] y;
    int         exp_sum;
  } vec_t;

  vec_t vecs[4];

  sc_mac_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .abort     (abort),
    .mac_x     (mac_x),
    .mac_y     (mac_y),
    .mac_clr   (mac_clr),
    .mac_q     (mac_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // k = cycle index after the handshake edge; k=1 LOAD, 2..3 FLUSH, 4..131 STREAM.
  function automatic logic qbit(input int mode, input int k);
    case (mode)
      1:       return 1'b1;
      2:       return logic'((k >= 4) && (((k - 4) % 2) == 0));
      3:       return logic'(k <= 3);
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge. Runs one term. If abort_k > 0, abort is raised in cycle k
  // and the term is left early.
  task automatic do_term(input int mode, input logic [6:0] x, input logic [6:0] y,
                         input bit last, input int abort_k);
    int bad_clr = 0;
    int bad_rdy = 0;
    int bad_ops = 0;
    int waitc   = 0;
    while (!in_ready && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 300) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    mac_q = qbit(mode, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= TERM_CYC; k++) begin
      if (mac_clr !== (k == 1)) bad_clr++;
      if (in_ready !== 1'b0) bad_rdy++;
      if (k >= 4 && (mac_x !== x || mac_y !== y)) bad_ops++;
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        return;
      end
      mac_q = qbit(mode, k);
      @(negedge clk);
    end
    check("mac_clr_pulse_bad_cycles", bad_clr, 0);
    check("in_ready_gap_bad_cycles", bad_rdy, 0);
    check("mac_xy_held_bad_cycles", bad_ops, 0);
    if (last) check("in_ready_in_done", int'(in_ready), 0);
    else      check("in_ready_after_term", int'(in_ready), 1);
  endtask

  // Called at the negedge after the DONE entry edge.
  task automatic drain(input int exp_sum, input logic [6:0] x);
    int bad = 0;
    check("out_valid", int'(out_valid), 1);
    check("out_sum", int'(out_sum), exp_sum);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = logic'(i % 2 == 0);
      in_x = ~x;
      @(negedge clk);
      if (out_valid !== 1'b1 || int'(out_sum) != exp_sum || in_ready !== 1'b0 ||
          busy !== 1'b1 || mac_x !== x) bad++;
    end
    in_valid = 1'b0;
    check("backpressure_bad_cycles", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_accept_out_valid", int'(out_valid), 0);
    check("post_accept_in_ready", int'(in_ready), 1);
    check("post_accept_busy", int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{3, 7'd35,  7'd100, 0};
    vecs[1] = '{0, 7'd12,  7'd90,  0};
    vecs[2] = '{2, 7'd64,  7'd64,  256};
    vecs[3] = '{1, 7'd127, 7'd1,   512};

    // Reset state
    #2 rst = 1'b1;
    #2;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_mac_clr", int'(mac_clr), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_out_sum", int'(out_sum), 0);
    check("reset_mac_x", int'(mac_x), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven four-term dot products with backpressure on each result
    for (int v = 0; v < 4; v++) begin
      for (int t = 0; t < 4; t++)
        do_term(vecs[v].mode, vecs[v].x, vecs[v].y, t == 3, 0);
      drain(vecs[v].exp_sum, vecs[v].x);
    end

    // Abort during STREAM of term 3, then a term, abort in IDLE with a
    // simultaneous handshake, then a clean four-term run
    do_term(1, 7'd20, 7'd21, 1'b0, 0);
    do_term(1, 7'd20, 7'd21, 1'b0, 0);
    do_term(1, 7'd20, 7'd21, 1'b0, 60);
    do_term(1, 7'd22, 7'd23, 1'b0, 0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_x = 7'd9;
    in_y = 7'd9;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    check("idle_abort_in_ready", int'(in_ready), 1);
    check("idle_abort_no_latch", int'(mac_x), 22);
    for (int t = 0; t < 4; t++) do_term(1, 7'd5, 7'd6, t == 3, 0);
    drain(512, 7'd5);

    // Async reset in FLUSH
    in_x = 7'd35;
    in_y = 7'd100;
    in_valid = 1'b1;
    mac_q = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_mac_clr", int'(mac_clr), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_mac_x", int'(mac_x), 0);
    check("midrst_mac_y", int'(mac_y), 0);
    check("midrst_out_sum", int'(out_sum), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 4; t++) do_term(1, 7'd35, 7'd100, t == 3, 0);
    drain(512, 7'd35);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sc_mac_seq.md
Name: sc_mac_seq

Overview:
Sequencer for one stochastic-computing MAC lane. It accepts BN operand pairs over a valid/ready handshake and drives them onto the MAC's 7-bit BN_X/BN_Y inputs. For each pair it clears the MAC's SNGs/LFSR, waits out the MAC pipeline, then counts the ones in the MAC output stream Q over one full stream window. It accumulates NTERMS such counts into a binary dot-product result, presented on a valid/ready output port.

Parameters:
BW, 7, operand width; matches SNG/LFSR width
STREAM_LEN, 128, cycles per stochastic window (2^BW)
PIPE_LAT, 2, MAC cycles from clear to first valid Q bit (SN_P/sel reg + sc_sum)
NTERMS, 4, operand pairs per dot product
ACC_W, 10, accumulator width; must hold STREAM_LEN*NTERMS

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept a pair
in_x  in  BW  BN operand X
in_y  in  BW  BN operand Y
abort  in  1  synchronous abort of current dot product
mac_x  out  BW  to MAC BN_X
mac_y  out  BW  to MAC BN_Y
mac_clr  out  1  one-cycle clear to MAC SNGs/LFSR; integrator ORs it into the MAC reset
mac_q  in  1  MAC stochastic output Q
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  ACC_W  accumulated ones count
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; in_ready=1; out_valid=0; mac_clr=0; busy=0.
  - mac_x, mac_y, out_sum, accumulator, window counter, term index all = 0.
- FSM states: IDLE, LOAD, FLUSH, STREAM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: latch in_x/in_y into mac_x/mac_y (held stable until the next accepted pair), then go to LOAD.
- LOAD (1 cycle, cycle after E0):
  - mac_clr=1; zero the per-window ones counter; go to FLUSH.
- FLUSH (PIPE_LAT cycles):
  - mac_q is ignored; then go to STREAM.
- STREAM (exactly STREAM_LEN cycles):
  - Each cycle, ones counter += mac_q.
  - On the final STREAM cycle:
    - accumulator += ones counter + mac_q (that cycle's bit included).
    - Term index increments.
    - If the index reaches NTERMS, go to DONE; otherwise go to IDLE.
- Per-term latency:
  - E0 to in_ready high again = 1+PIPE_LAT+STREAM_LEN = 131 cycles (defaults).
  - Counted window covers cycles E0+PIPE_LAT+2 through E0+PIPE_LAT+1+STREAM_LEN.
- DONE:
  - out_valid=1; out_sum = accumulator; in_ready=0.
  - Hold out_sum/out_valid stable until out_ready=1.
  - At that edge: clear accumulator and term index, return to IDLE, out_valid=0.
- Arithmetic:
  - Unsigned throughout.
  - Ones counter width is clog2(STREAM_LEN+1).
  - No saturation required: parameter rule guarantees no overflow.
- abort:
  - Honoured in any non-IDLE state.
  - Next edge: IDLE, accumulator/term index/ones counter cleared, out_valid=0, mac_clr=0.
  - Any partial sum is discarded.
  - abort in IDLE: clears accumulator/term index only.
  - abort takes priority over a same-cycle handshake; that pair is not accepted.
- in_valid outside IDLE: ignored; in_ready=0, nothing latched.
- Async reset mid-operation: immediate return to reset values; no result emitted.

Test Plan:
- mac_q tied 1, four pairs back-to-back:
  - out_valid asserts with out_sum=512.
  - Each in_ready gap is 131 cycles.
- mac_q tied 0 -> out_sum=0.
- mac_q toggling 1/0 every cycle during STREAM -> 64 per term, out_sum=256.
- mac_q=1 only during LOAD/FLUSH, 0 during STREAM -> out_sum=0.
  - mac_clr is high exactly one cycle, the cycle after each handshake.
  - mac_x/mac_y equal the latched pair (e.g. 35/100) through STREAM.
- Backpressure: in DONE, hold out_ready=0 for 10 cycles -> out_valid, out_sum stable; in_ready=0; in_valid pulses ignored.
- abort asserted in STREAM of term 3 -> busy=0 next cycle.
  - The following four-term run with mac_q=1 yields 512, not 896.
- rst pulsed mid-FLUSH -> all outputs at reset values asynchronously.
